// File: rtl/mod_mult_pkg.sv
// Shared constants and types for the mod_mult multiply/divide unit.
// MTHI/MTLO behaviour is gated by the MOD_MULT_MTHILO_EN macro in the top.
package mod_mult_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int unsigned CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAT_MULT = 4'd5;
    localparam cnt_t LAT_DIV  = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return op <= OP_DIVU;
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_move(input logic [2:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/mod_mult_div.sv
// Combinational 32-bit divider: signed (truncating) or unsigned quotient/remainder.
// A zero divisor yields zeros; the caller discards that result.
module mod_mult_div (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Divide magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude,
    // so the most-negative / -1 case falls out without overflow handling.
    always_comb begin
        a_neg = is_signed & dividend[31];
        b_neg = is_signed & divisor[31];
        a_mag = a_neg ? (32'd0 - dividend) : dividend;
        b_mag = b_neg ? (32'd0 - divisor)  : divisor;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        remainder = a_neg ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/mod_mult.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Define MOD_MULT_MTHILO_EN to enable single-edge MTHI/MTLO writes.
module mod_mult
    import mod_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] C,
    input  logic [31:0] D,
    input  logic [2:0]  mult_ctr,
    input  logic        start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy
);

    state_t      state;
    cnt_t        cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] prod;
    logic        div_signed;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        div_signed = (op_q == OP_DIV);
        if (op_q == OP_MULT)
            prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        else
            prod = {32'd0, a_q} * {32'd0, b_q};
    end

    mod_mult_div u_div (
        .dividend  (a_q),
        .divisor   (b_q),
        .is_signed (div_signed),
        .quotient  (quot),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            HI    <= '0;
            LO    <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_arith(mult_ctr)) begin
                        op_q  <= mult_ctr;
                        a_q   <= C;
                        b_q   <= D;
                        cnt   <= is_mult(mult_ctr) ? (LAT_MULT - 4'd1) : (LAT_DIV - 4'd1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
`ifdef MOD_MULT_MTHILO_EN
                    else if (start && is_move(mult_ctr)) begin
                        if (mult_ctr == OP_MTHI)
                            HI <= C;
                        else
                            LO <= C;
                    end
`endif
                end
                RUN: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (is_mult(op_q)) begin
                            HI <= prod[63:32];
                            LO <= prod[31:0];
                        end else if (b_q != '0) begin
                            HI <= rem;
                            LO <= quot;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mult.sv
// Self-checking bench for mod_mult: behavioural HI/LO/busy model plus directed literal cases.
// Expectations for codes 4/5 follow MOD_MULT_MTHILO_EN.
module tb_mod_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] C = '0;
    logic [31:0] D = '0;
    logic [2:0]  mult_ctr = '0;
    logic        start = 1'b0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mod_mult dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .C        (C),
        .D        (D),
        .mult_ctr (mult_ctr),
        .start    (start),
        .HI       (HI),
        .LO       (LO),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an op occupies 'latency' edges, then {HI,LO} take the arithmetic result.
    bit          m_busy;
    bit [31:0]   m_hi;
    bit [31:0]   m_lo;
    int          m_left;
    bit [2:0]    m_op;
    bit [31:0]   m_a;
    bit [31:0]   m_b;

    function automatic bit [63:0] model_res(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                                            input bit [31:0] hi, input bit [31:0] lo);
        longint          sa, sb, sp, q, r;
        longint unsigned up;
        bit [63:0]       res;
        res = {hi, lo};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin sp = sa * sb; res = sp; end
            3'd1: begin up = 64'(a) * 64'(b); res = up; end
            3'd2: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            3'd3: if (b != 0) res = {a % b, a / b};
            default: ;
        endcase
        return res;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                {m_hi, m_lo} <= model_res(m_op, m_a, m_b, m_hi, m_lo);
            end
        end else if (start) begin
            if (mult_ctr <= 3'd3) begin
                m_op   <= mult_ctr;
                m_a    <= C;
                m_b    <= D;
                m_left <= (mult_ctr <= 3'd1) ? 5 : 10;
                m_busy <= 1'b1;
            end
`ifdef MOD_MULT_MTHILO_EN
            else if (mult_ctr == 3'd4) m_hi <= C;
            else if (mult_ctr == 3'd5) m_lo <= C;
`endif
        end
    end

    always @(negedge clk) begin
        check32("busy", {31'd0, busy}, {31'd0, m_busy});
        check32("HI", HI, m_hi);
        check32("LO", LO, m_lo);
    end

    // Caller is at a negedge; returns at the first negedge with busy low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit glitch);
        int cnt;
        int exp_len;
        exp_len = (op <= 3'd1) ? 5 : (op <= 3'd3) ? 10 : 0;
        mult_ctr = op;
        C = a;
        D = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 64) begin
            cnt++;
            if (glitch && cnt == 3) begin
                start = 1'b1;
                mult_ctr = 3'($urandom);
                C = $urandom;
                D = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check32("busy_len", 32'(cnt), 32'(exp_len));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;

        #12;
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_HI", HI, 32'd0);
        check32("rst_LO", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0);
        check32("divu_LO", LO, 32'h0001_0001);
        check32("divu_HI", HI, 32'h0000_0000);

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0);
        check32("mult_HI", HI, 32'hFFFF_FFFF);
        check32("mult_LO", LO, 32'hFFFF_0001);

        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0);
        check32("multu_HI", HI, 32'h0000_FFFE);
        check32("multu_LO", LO, 32'hFFFF_0001);

        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0);
        check32("div_LO", LO, 32'h0000_0000);
        check32("div_HI", HI, 32'hFFFF_FFFF);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check32("divovf_LO", LO, 32'h8000_0000);
        check32("divovf_HI", HI, 32'h0000_0000);

        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check32("divneg_LO", LO, 32'hFFFF_FFFD);
        check32("divneg_HI", HI, 32'hFFFF_FFFF);

        run_op(3'd3, 32'h1234_5678, 32'h0000_0000, 1'b1);
        check32("div0_LO", LO, 32'hFFFF_FFFD);
        check32("div0_HI", HI, 32'hFFFF_FFFF);

        run_op(3'd0, 32'h0000_0007, 32'h0000_0006, 1'b1);
        check32("glitch_LO", LO, 32'h0000_002A);
        check32("glitch_HI", HI, 32'h0000_0000);

        run_op(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0);
        run_op(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0);
        check32("rsv_LO", LO, 32'h0000_002A);

        run_op(3'd4, 32'h1234_5678, 32'h0, 1'b0);
        run_op(3'd5, 32'h9ABC_DEF0, 32'h0, 1'b0);
`ifdef MOD_MULT_MTHILO_EN
        check32("mthi_HI", HI, 32'h1234_5678);
        check32("mtlo_LO", LO, 32'h9ABC_DEF0);
`else
        check32("mthi_HI", HI, 32'h0000_0000);
        check32("mtlo_LO", LO, 32'h0000_002A);
`endif

        mult_ctr = 3'd2;
        C = 32'h0000_0064;
        D = 32'h0000_0007;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("midrst_busy", {31'd0, busy}, 32'd0);
        check32("midrst_HI", HI, 32'd0);
        check32("midrst_LO", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'h0000_0003, 32'h0000_0004, 1'b0);
        check32("postrst_LO", LO, 32'h0000_000C);
        check32("postrst_HI", HI, 32'h0000_0000);

        for (int i = 0; i < 300; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            hold_hi = m_hi;
            hold_lo = m_lo;
            run_op(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            if (hold_hi == 32'h0 && hold_lo == 32'h0 && i == 299) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
